// File: rtl/pt_tx_sequencer_pkg.sv
// rtl/pt_tx_sequencer_pkg.sv - shared widths, defaults and FSM state type for the PT2262 tx sequencer
package pt_tx_sequencer_pkg;

    localparam int PT_PAYLOAD_W      = 24;
    localparam int PT_DEFAULT_REPEAT = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        GAP  = 2'd3
    } pt_state_e;

endpackage

// File: rtl/pt_payload_slot.sv
// rtl/pt_payload_slot.sv - one-entry pending payload register with drop-on-full overflow pulse
module pt_payload_slot
    import pt_tx_sequencer_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    push,
    input  logic [PT_PAYLOAD_W-1:0] din,
    input  logic                    pop,
    output logic [PT_PAYLOAD_W-1:0] dout,
    output logic                    valid,
    output logic                    overflow
);

    logic [PT_PAYLOAD_W-1:0] data_q, data_d;
    logic                    valid_q, valid_d;
    logic                    ovf_q, ovf_d;

    // A pop in the same cycle frees the entry, so a simultaneous push is accepted.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        ovf_d   = 1'b0;
        if (pop) begin
            valid_d = 1'b0;
        end
        if (push) begin
            if (!valid_q || pop) begin
                data_d  = din;
                valid_d = 1'b1;
            end else begin
                ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
        end
    end

    assign dout     = data_q;
    assign valid    = valid_q;
    assign overflow = ovf_q;

endmodule

// File: rtl/pt_tx_sequencer.sv
// rtl/pt_tx_sequencer.sv - repeats each 24-bit payload as REPEAT_COUNT pt_enc frames with optional idle gap
module pt_tx_sequencer
    import pt_tx_sequencer_pkg::*;
#(
    parameter int REPEAT_COUNT = PT_DEFAULT_REPEAT,
    parameter int GAP_CYCLES   = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    pl_valid,
    input  logic [PT_PAYLOAD_W-1:0] pl_data,
    output logic                    rx_ready,
    output logic                    enc_ld,
    output logic [PT_PAYLOAD_W-1:0] enc_ad,
    input  logic                    enc_done,
    output logic                    busy,
    output logic                    overflow
);

    localparam int REP_W = $clog2(REPEAT_COUNT + 1);
    localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [REP_W-1:0] REP_MAX  = REP_W'(REPEAT_COUNT);
    localparam logic [GAP_W-1:0] GAP_INIT = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    pt_state_e               state_q, state_d;
    logic                    ld_q, ld_d;
    logic [PT_PAYLOAD_W-1:0] ad_q, ad_d;
    logic [REP_W-1:0]        rep_q, rep_d, rep_inc;
    logic [GAP_W-1:0]        gap_q, gap_d;
    logic                    pop;
    logic                    pend_v;
    logic [PT_PAYLOAD_W-1:0] pend_data;

    pt_payload_slot u_slot (
        .clk      (clk),
        .reset    (reset),
        .push     (pl_valid),
        .din      (pl_data),
        .pop      (pop),
        .dout     (pend_data),
        .valid    (pend_v),
        .overflow (overflow)
    );

    assign rep_inc = rep_q + REP_W'(1);

    always_comb begin
        state_d = state_q;
        ld_d    = 1'b0;
        ad_d    = ad_q;
        rep_d   = rep_q;
        gap_d   = gap_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                // Wait for the encoder too, so a frame still running across a reset is not clobbered.
                if (pend_v && enc_done) begin
                    pop     = 1'b1;
                    ad_d    = pend_data;
                    rep_d   = '0;
                    ld_d    = 1'b1;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (enc_done) begin
                    ld_d = 1'b1;
                end else begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (enc_done) begin
                    rep_d = rep_inc;
                    if (GAP_CYCLES > 0) begin
                        gap_d   = GAP_INIT;
                        state_d = GAP;
                    end else if (rep_inc == REP_MAX) begin
                        state_d = IDLE;
                    end else begin
                        ld_d    = 1'b1;
                        state_d = LOAD;
                    end
                end
            end
            GAP: begin
                if (gap_q == '0) begin
                    if (rep_q < REP_MAX) begin
                        ld_d    = 1'b1;
                        state_d = LOAD;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    gap_d = gap_q - GAP_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            ld_q    <= 1'b0;
            ad_q    <= '0;
            rep_q   <= '0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            ld_q    <= ld_d;
            ad_q    <= ad_d;
            rep_q   <= rep_d;
            gap_q   <= gap_d;
        end
    end

    assign rx_ready = !pend_v;
    assign enc_ld   = ld_q;
    assign enc_ad   = ad_q;
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_pt_tx_sequencer.sv
// tb/tb_pt_tx_sequencer.sv - three sequencer configurations against behavioural pt_enc models and a frame scoreboard
module tb_pt_tx_sequencer;

    localparam int RA = 16, GA = 0;
    localparam int RG = 3,  GG = 5;
    localparam int RS = 1,  GS = 0;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic pv_a = 1'b0, pv_g = 1'b0, pv_s = 1'b0;
    logic [23:0] pd_a = '0, pd_g = '0, pd_s = '0;
    logic rdy_a, rdy_g, rdy_s, ld_a, ld_g, ld_s, busy_a, busy_g, busy_s, ovf_a, ovf_g, ovf_s;
    logic [23:0] ad_a, ad_g, ad_s;
    logic done_a = 1'b1, done_g = 1'b1, done_s = 1'b1;
    int cnt_a = 0, cnt_g = 0, cnt_s = 0;

    pt_tx_sequencer #(.REPEAT_COUNT(RA), .GAP_CYCLES(GA)) u_dut_a (
        .clk(clk), .reset(reset), .pl_valid(pv_a), .pl_data(pd_a), .rx_ready(rdy_a),
        .enc_ld(ld_a), .enc_ad(ad_a), .enc_done(done_a), .busy(busy_a), .overflow(ovf_a));
    pt_tx_sequencer #(.REPEAT_COUNT(RG), .GAP_CYCLES(GG)) u_dut_g (
        .clk(clk), .reset(reset), .pl_valid(pv_g), .pl_data(pd_g), .rx_ready(rdy_g),
        .enc_ld(ld_g), .enc_ad(ad_g), .enc_done(done_g), .busy(busy_g), .overflow(ovf_g));
    pt_tx_sequencer #(.REPEAT_COUNT(RS), .GAP_CYCLES(GS)) u_dut_s (
        .clk(clk), .reset(reset), .pl_valid(pv_s), .pl_data(pd_s), .rx_ready(rdy_s),
        .enc_ld(ld_s), .enc_ad(ad_s), .enc_done(done_s), .busy(busy_s), .overflow(ovf_s));

    // pt_enc stand-in: done drops the cycle after ld is seen, stays low 20 cycles; unaffected by reset
    always @(posedge clk) begin
        if (done_a && ld_a) begin done_a <= 1'b0; cnt_a <= 19; end
        else if (!done_a) begin if (cnt_a == 0) done_a <= 1'b1; else cnt_a <= cnt_a - 1; end
    end
    always @(posedge clk) begin
        if (done_g && ld_g) begin done_g <= 1'b0; cnt_g <= 19; end
        else if (!done_g) begin if (cnt_g == 0) done_g <= 1'b1; else cnt_g <= cnt_g - 1; end
    end
    always @(posedge clk) begin
        if (done_s && ld_s) begin done_s <= 1'b0; cnt_s <= 19; end
        else if (!done_s) begin if (cnt_s == 0) done_s <= 1'b1; else cnt_s <= cnt_s - 1; end
    end

    logic [23:0] got_a[$], got_g[$], got_s[$];
    int novf_a = 0, novf_g = 0, novf_s = 0, adchg_a = 0;
    logic ld_a_p = 1'b0, ld_g_p = 1'b0, ld_s_p = 1'b0, done_g_p = 1'b1;
    logic [23:0] ad_a_p = '0;
    int t_done_g = -1;
    int deltas_g[$];

    always @(negedge clk) begin
        if (reset) begin
            ld_a_p <= 1'b0;
            ad_a_p <= '0;
        end else begin
            if (ld_a && !ld_a_p) got_a.push_back(ad_a);
            else if (ad_a != ad_a_p) adchg_a <= adchg_a + 1;
            if (ovf_a) novf_a <= novf_a + 1;
            ld_a_p <= ld_a;
            ad_a_p <= ad_a;
        end
    end
    always @(negedge clk) begin
        if (!reset) begin
            if (ld_g && !ld_g_p) got_g.push_back(ad_g);
            if (ovf_g) novf_g <= novf_g + 1;
            if (done_g && !done_g_p) t_done_g <= cyc;
            if (ld_g && !ld_g_p && t_done_g >= 0) begin
                deltas_g.push_back(cyc - t_done_g);
                t_done_g <= -1;
            end
            if (ld_s && !ld_s_p) got_s.push_back(ad_s);
            if (ovf_s) novf_s <= novf_s + 1;
        end
        ld_g_p   <= ld_g;
        ld_s_p   <= ld_s;
        done_g_p <= done_g;
    end

    int n_tests = 0, n_fail = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push(input int which, input logic [23:0] d);
        case (which)
            0: begin pv_a = 1'b1; pd_a = d; end
            1: begin pv_g = 1'b1; pd_g = d; end
            default: begin pv_s = 1'b1; pd_s = d; end
        endcase
        @(posedge clk);
        @(negedge clk);
        pv_a = 1'b0; pv_g = 1'b0; pv_s = 1'b0;
    endtask

    task automatic wait_idle(input int which, input int budget, input string tag);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            case (which)
                0: ok = !busy_a && rdy_a && done_a;
                1: ok = !busy_g && rdy_g && done_g;
                default: ok = !busy_s && rdy_s && done_s;
            endcase
            if (ok) break;
        end
        check_eq({tag, "_idle"}, {31'd0, ok}, 32'd1);
    endtask

    task automatic check_frames(input string tag, input logic [23:0] got[$], input int base,
                                input logic [23:0] exp[$]);
        int bad;
        bad = 0;
        check_eq({tag, "_nframes"}, got.size() - base, exp.size());
        for (int i = 0; i < exp.size() && base + i < got.size(); i++)
            if (got[base + i] !== exp[i]) bad++;
        check_eq({tag, "_framedata"}, bad, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    initial begin
        logic [23:0] exp[$];
        logic [23:0] r1, r2, pa, pb, pc;
        int base, ob, bad;
        logic ok;

        repeat (3) @(negedge clk);
        check_eq("rst_ld", ld_a, 0);
        check_eq("rst_ad", ad_a, 0);
        check_eq("rst_busy", busy_a, 0);
        check_eq("rst_rdy", rdy_a, 1);
        check_eq("rst_ovf", ovf_a, 0);
        reset = 1'b0;
        @(negedge clk);

        // single payload, 16 frames, 2-cycle start latency
        base = got_a.size(); ob = novf_a;
        push(0, 24'hAAAA01);
        check_eq("t1_lat_cyc1", ld_a, 0);
        @(negedge clk);
        check_eq("t1_lat_cyc2", ld_a, 1);
        check_eq("t1_busy", busy_a, 1);
        wait_idle(0, 1000, "t1");
        exp = {};
        repeat (RA) exp.push_back(24'hAAAA01);
        check_frames("t1", got_a, base, exp);

        // two payloads 5 cycles apart plus a third into a full slot
        base = got_a.size(); ob = novf_a;
        push(0, 24'h000001);
        repeat (4) @(negedge clk);
        push(0, 24'h0000AA);
        check_eq("t2_rdy_low", rdy_a, 0);
        push(0, 24'h123456);
        repeat (2) @(negedge clk);
        check_eq("t3_ovf_pulse", novf_a - ob, 1);
        ok = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            if (rdy_a) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        check_eq("t2_rdy_wait", {31'd0, ok}, 1);
        check_eq("t2_pop_ld", ld_a, 1);
        check_eq("t2_pop_ad", ad_a, 24'h0000AA);
        wait_idle(0, 1500, "t2");
        exp = {};
        repeat (RA) exp.push_back(24'h000001);
        repeat (RA) exp.push_back(24'h0000AA);
        check_frames("t2", got_a, base, exp);
        check_eq("t3_ovf_total", novf_a - ob, 1);
        check_eq("t2_ad_stable", adchg_a, 0);

        // reset during frame 7
        r1 = 24'($urandom);
        r2 = 24'($urandom);
        base = got_a.size();
        push(0, r1);
        ok = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            if (got_a.size() - base == 7) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        check_eq("t4_reach_f7", {31'd0, ok}, 1);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1;
        check_eq("t4_rst_ld", ld_a, 0);
        check_eq("t4_rst_busy", busy_a, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_eq("t4_post_rdy", rdy_a, 1);
        check_eq("t4_post_busy", busy_a, 0);
        exp = {};
        repeat (7) exp.push_back(r1);
        check_frames("t4_pre", got_a, base, exp);
        base = got_a.size();
        push(0, r2);
        wait_idle(0, 1000, "t4");
        exp = {};
        repeat (RA) exp.push_back(r2);
        check_frames("t4_post", got_a, base, exp);

        // gap: the RUN cycle seeing done high, then GG idle cycles, then ld
        base = got_g.size();
        r1 = 24'($urandom);
        push(1, r1);
        wait_idle(1, 500, "t5");
        exp = {};
        repeat (RG) exp.push_back(r1);
        check_frames("t5", got_g, base, exp);
        check_eq("t5_ngaps", deltas_g.size(), RG - 1);
        bad = 0;
        foreach (deltas_g[i]) if (deltas_g[i] != GG + 1) bad++;
        check_eq("t5_gap_len", bad, 0);

        // REPEAT_COUNT=1 with push landing on the pop cycle
        base = got_s.size(); ob = novf_s;
        pa = 24'($urandom); pb = 24'($urandom); pc = 24'($urandom);
        push(2, pa);
        repeat (2) @(negedge clk);
        push(2, pb);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (done_s) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        check_eq("t6_done_wait", {31'd0, ok}, 1);
        @(negedge clk);
        push(2, pc);
        check_eq("t6_rdy_captured", rdy_s, 0);
        wait_idle(2, 500, "t6");
        exp = {pa, pb, pc};
        check_frames("t6", got_s, base, exp);
        check_eq("t6_no_ovf", novf_s - ob, 0);

        // randomized payloads and spacing, each pushed once the slot reports ready
        for (int k = 0; k < 2; k++) begin
            int which;
            which = k + 1;
            base = (which == 1) ? got_g.size() : got_s.size();
            ob = (which == 1) ? novf_g : novf_s;
            exp = {};
            for (int n = 0; n < 4; n++) begin
                r1 = 24'($urandom);
                ok = 1'b0;
                for (int i = 0; i < 500; i++) begin
                    if ((which == 1) ? rdy_g : rdy_s) begin ok = 1'b1; break; end
                    @(negedge clk);
                end
                check_eq("rnd_rdy_wait", {31'd0, ok}, 1);
                repeat ($urandom_range(0, 4)) @(negedge clk);
                push(which, r1);
                repeat ((which == 1) ? RG : RS) exp.push_back(r1);
            end
            wait_idle(which, 1000, "rnd");
            if (which == 1) begin
                check_frames("rnd_g", got_g, base, exp);
                check_eq("rnd_g_ovf", novf_g - ob, 0);
            end else begin
                check_frames("rnd_s", got_s, base, exp);
                check_eq("rnd_s_ovf", novf_s - ob, 0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
